multi_key_debounce: RTL and testbench

- N-channel successor to the single-key debounce/edge block feeding map_display's move_up/down/left/right.
- Each channel: 2-flop synchroniser, counter-based debounce, press and release edge pulses, and a per-channel hold-to-repeat FSM so that a held direction key produces repeated move pulses.
- Sits between the board switches/buttons and game logic in the 100 MHz clk_bufg domain.

---
 rtl/multi_key_debounce.sv | 159 +++++++++++++++
 tb/tb_multi_key_debounce.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multi_key_debounce.sv
// N-channel key conditioner: 2-flop synchroniser, counter debounce, press/release pulses.
// Hold-to-repeat FSMs are built only when KEY_REPEAT_EN is defined; otherwise key_rpt mirrors key_pos.
module multi_key_debounce #(
    parameter int N_KEYS     = 4,
    parameter int DB_CYCLES  = 2000000,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pos,
    output logic [N_KEYS-1:0] key_neg,
    output logic [N_KEYS-1:0] key_rpt,
    output logic              any_pos
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    if (N_KEYS < 1 || DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_params
        $error("multi_key_debounce: N_KEYS, DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 1");
    end

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sync;
    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] level_next;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] fall;
    logic [N_KEYS-1:0] rpt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= key;
            sync      <= sync_meta;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_db
        logic [DB_W-1:0] db_cnt;

        // Level flips on the cycle the counter sits at its last value while the input still disagrees.
        assign toggle[i] = (sync[i] != key_level[i]) && (db_cnt == DB_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
            end else if ((sync[i] == key_level[i]) || toggle[i]) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign level_next = key_level ^ toggle;
    assign rise       = toggle & ~key_level;
    assign fall       = toggle & key_level;

`ifdef KEY_REPEAT_EN
    localparam int               RPT_MAX     = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int               RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_rpt
        rpt_state_t       state_q;
        rpt_state_t       state_d;
        logic [RPT_W-1:0] cnt_q;
        logic [RPT_W-1:0] cnt_d;
        logic             rpt_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // The FSM looks at the level being loaded this edge, so a release beats a coincident repeat.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rpt_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise[i]) begin
                        rpt_d   = 1'b1;
                        state_d = DELAY;
                        cnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (!level_next[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DELAY_LAST) begin
                        rpt_d   = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_next[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == PERIOD_LAST) begin
                        rpt_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign rpt_next[i] = rpt_d;
    end
`else
    assign rpt_next = rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= '0;
            key_pos   <= '0;
            key_neg   <= '0;
            key_rpt   <= '0;
            any_pos   <= 1'b0;
        end else begin
            key_level <= level_next;
            key_pos   <= rise;
            key_neg   <= fall;
            key_rpt   <= rpt_next;
            any_pos   <= |rise;
        end
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce with small timing parameters.
// Repeat expectations follow KEY_REPEAT_EN so the same bench serves both builds.
module tb_multi_key_debounce;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DB + 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_level;
    logic [3:0] key_pos;
    logic [3:0] key_neg;
    logic [3:0] key_rpt;
    logic       any_pos;

    int checks;
    int errors;

    multi_key_debounce #(
        .N_KEYS    (4),
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .key_level(key_level),
        .key_pos  (key_pos),
        .key_neg  (key_neg),
        .key_rpt  (key_rpt),
        .any_pos  (any_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Repeat pulses at press p, p+RD, p+RD+n*RP, none from the fall cycle f onwards.
    function automatic logic exp_rpt_at(input int t, input int p, input int f);
`ifdef KEY_REPEAT_EN
        if (t == p) return 1'b1;
        if (t >= p + RD && t < f && ((t - p - RD) % RP) == 0) return 1'b1;
        return 1'b0;
`else
        return (t == p);
`endif
    endfunction

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] pos,
                             input logic [3:0] neg, input logic [3:0] rpt);
        check({tag, "/level"}, key_level, lvl);
        check({tag, "/pos"}, key_pos, pos);
        check({tag, "/neg"}, key_neg, neg);
        check({tag, "/rpt"}, key_rpt, rpt);
        check({tag, "/any_pos"}, any_pos, |pos);
    endtask

    // Press the masked keys just after edge E, release just after edge E+hold, check every cycle.
    task automatic run_hold(input string tag, input logic [3:0] mask, input int hold);
        int fall_at;
        fall_at = hold + LAT;
        @(posedge clk);
        #1 key = key | mask;
        for (int j = 1; j <= fall_at + 4; j++) begin
            @(posedge clk);
            if (j == hold) #1 key = key & ~mask;
            @(negedge clk);
            check_all(tag,
                      (j >= LAT && j < fall_at) ? mask : 4'b0,
                      (j == LAT) ? mask : 4'b0,
                      (j == fall_at) ? mask : 4'b0,
                      exp_rpt_at(j, LAT, fall_at) ? mask : 4'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key    = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 4'b0, 4'b0, 4'b0, 4'b0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_hold("clean0", 4'b0001, 10);

        // Bounce on key 1: high 3 cycles, low 2, then held high.
        @(posedge clk);
        #1 key[1] = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            @(posedge clk);
            if (j == 3) #1 key[1] = 1'b0;
            if (j == 5) #1 key[1] = 1'b1;
            @(negedge clk);
            check_all("bounce1",
                      (j >= 11) ? 4'b0010 : 4'b0,
                      (j == 11) ? 4'b0010 : 4'b0,
                      4'b0,
                      (j == 11) ? 4'b0010 : 4'b0);
        end
        @(posedge clk);
        #1 key[1] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("bounce1_rel",
                      (j < LAT) ? 4'b0010 : 4'b0,
                      4'b0,
                      (j == LAT) ? 4'b0010 : 4'b0,
                      4'b0);
        end

        run_hold("repeat2", 4'b0100, 51);
        run_hold("collide2", 4'b0100, 20);
        run_hold("simul", 4'b1111, 36);

        // Asynchronous reset while key 3 is deep in its repeat phase.
        @(posedge clk);
        #1 key = 4'b1000;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rst_mid/held_level", key_level, 4'b1000);
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid/async", 4'b0, 4'b0, 4'b0, 4'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("rst_mid/repress",
                      (j >= LAT) ? 4'b1000 : 4'b0,
                      (j == LAT) ? 4'b1000 : 4'b0,
                      4'b0,
                      (j == LAT) ? 4'b1000 : 4'b0);
        end
        @(posedge clk);
        #1 key = 4'b0;
        repeat (12) @(posedge clk);

        run_hold("long0", 4'b0001, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
